booth8_ctrl: RTL and testbench
==============================

BOOTH8_CTRL -- requirements
Module: booth8_ctrl

Interface
REQ-001 The block SHALL have one parameter: ITER, default 3, number of radix-8 iterations (8-bit multiplier padded to 9 bits).
REQ-002 The port Clock SHALL be an input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The port Reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 The port Start SHALL be an input, 1 bit: request one multiplication; sampled only in IDLE.
REQ-005 The port Win SHALL be an input, 4 bits: Booth window from the datapath multiplier register, {Q[2:0], Q_-1}.
REQ-006 The port Load SHALL be an output, 1 bit: datapath loads Mplier/Mplicand and clears the accumulator.
REQ-007 The port Pre3 SHALL be an output, 1 bit: datapath computes and stores 3M = M + 2M.
REQ-008 The port Add SHALL be an output, 1 bit: accumulator += selected multiple.
REQ-009 The port Addc SHALL be an output, 1 bit: accumulator += two's complement of the selected multiple.
REQ-010 The port Sel SHALL be an output, 2 bits: multiple select, where 0 = M, 1 = 2M, 2 = 3M, 3 = 4M.
REQ-011 The port Shift SHALL be an output, 1 bit: arithmetic right shift of {acc, Q, Q_-1} by 3.
REQ-012 The port Busy SHALL be an output, 1 bit: high in every state except IDLE.
REQ-013 The port Done SHALL be an output, 1 bit: one-cycle pulse when Product is valid.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, LOAD, PRE, EVAL, ADD, SHIFT and DONE.
REQ-015 The FSM SHALL make these transitions:
- IDLE to LOAD when Start=1.
- LOAD to PRE.
- PRE to EVAL.
- EVAL to SHIFT when the digit is 0; otherwise EVAL to ADD.
- ADD to SHIFT.
- SHIFT to DONE when cnt = ITER-1; otherwise SHIFT to EVAL with cnt+1.
- DONE to IDLE.
REQ-016 The outputs SHALL be Moore, decoded from the registered state only:
- Load=1 only in LOAD.
- Pre3=1 only in PRE.
- Shift=1 only in SHIFT.
- Done=1 only in DONE.
- Add or Addc=1 only in ADD.
REQ-017 The recoded digit SHALL be d = -4*Win[3] + 2*Win[2] + Win[1] + Win[0], giving d in the range -4..+4.
REQ-018 On the EVAL-to-ADD transition, the block SHALL register sign = Win[3] and Sel = |d|-1, and hold both through ADD.
REQ-019 In ADD, the block SHALL drive Add=1 when sign=0 and Addc=1 when sign=1; Add and Addc SHALL never both be 1.
REQ-020 Win=0000 and Win=1111 SHALL both decode to d=0, so no ADD cycle is inserted.
REQ-021 The iteration counter cnt SHALL be 2 bits, cleared in LOAD, incremented only in SHIFT, and never wrap within one operation.
REQ-022 Sel SHALL be 0 whenever the FSM is not in ADD.
REQ-023 Latency, from the cycle Start is sampled to Done high, SHALL be 2 + 2*ITER + (number of nonzero digits) + 1 cycles: 9 minimum and 12 maximum for ITER=3.
REQ-024 A Start received while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 A Start held high during DONE SHALL NOT act until IDLE, so back-to-back operations have Busy=0 for at least one cycle between them.
REQ-026 The block SHALL hold no datapath state; the datapath presents Win from its current register contents, valid in every EVAL cycle.

Reset
REQ-027 When Reset=1 at a rising Clock edge, the block SHALL enter IDLE with cnt=0, sign=0 and Sel=0.
REQ-028 In the cycle after a reset edge, all outputs (Load, Pre3, Add, Addc, Shift, Busy, Done) SHALL be 0.
REQ-029 Reset SHALL take priority over Start and over every state transition, including a reset arriving mid-operation (ADD or SHIFT); no further control pulses are then issued.
REQ-030 After reset is released, the block SHALL accept a new Start in the first IDLE cycle.

Verification
REQ-031 Zero digits: Start, with Win=0000 in all three EVALs.
- Sequence SHALL be Load, Pre3, then Shift x3 with no Add or Addc.
- Done SHALL be high 9 cycles after Start.
REQ-032 Full digits: Win=0111, then 0101, then 1000.
- Iteration 1 SHALL give Add with Sel=3.
- Iteration 2 SHALL give Add with Sel=2.
- Iteration 3 SHALL give Addc with Sel=3.
- Done SHALL be high 12 cycles after Start.
REQ-033 End-to-end with the datapath: Mplier=8'hFF (-1) and Mplicand=8'h07.
- Digits SHALL be -1, 0, 0.
- Product SHALL be 16'hFFF9 at Done.
REQ-034 Mid-operation reset: Reset=1 while in the first ADD.
- Next cycle SHALL show Busy=0 and Add=Addc=Shift=0.
- A Start 2 cycles later SHALL produce a full, correct sequence.
REQ-035 Busy Start: Start pulsed during SHIFT of iteration 2.
- The pulse SHALL be ignored, with exactly one Done and one Load.
REQ-036 Repeated Start: Start held high continuously.
- Done pulses SHALL recur every latency + 1 cycles, with Busy=0 for one cycle between operations.

Source files
------------

// File: rtl/booth8_ctrl_if.sv
// Control/handshake bundle between the radix-8 Booth controller and its datapath.
interface booth8_ctrl_if;
  logic       Start;
  logic [3:0] Win;
  logic       Load;
  logic       Pre3;
  logic       Add;
  logic       Addc;
  logic [1:0] Sel;
  logic       Shift;
  logic       Busy;
  logic       Done;

  // Requester / datapath side: issues Start, presents the Booth window.
  modport master (
    output Start, Win,
    input  Load, Pre3, Add, Addc, Sel, Shift, Busy, Done
  );

  // Controller side.
  modport slave (
    input  Start, Win,
    output Load, Pre3, Add, Addc, Sel, Shift, Busy, Done
  );
endinterface

// File: rtl/booth8_ctrl.sv
// Radix-8 Booth multiplier sequencer: walks LOAD/PRE/(EVAL[/ADD]/SHIFT)xITER/DONE.
// Every control output is a flop loaded from the decode of the next state, so
// each output equals a Moore decode of the current registered state.
module booth8_ctrl #(
  parameter int unsigned ITER = 3
) (
  input  logic         Clock,
  input  logic         Reset,
  booth8_ctrl_if.slave ctl
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned MAG_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PRE   = 3'd2,
    EVAL  = 3'd3,
    ADD   = 3'd4,
    SHIFT = 3'd5,
    DONE  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               load_q, load_d;
  logic               pre3_q, pre3_d;
  logic               add_q, add_d;
  logic               addc_q, addc_d;
  logic               shift_q, shift_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [MAG_W-1:0]   pos_c;
  logic [MAG_W-1:0]   mag_c;

  // Digit magnitude: positive part 2*W2+W1+W0, minus 4 when W3 is set.
  always_comb begin
    pos_c = MAG_W'({ctl.Win[2], 1'b0}) + MAG_W'(ctl.Win[1]) + MAG_W'(ctl.Win[0]);
    mag_c = ctl.Win[3] ? (MAG_W'(4) - pos_c) : pos_c;
  end

  // Next-state, counter, digit capture and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    sel_d   = '0;
    case (state_q)
      IDLE:  if (ctl.Start) state_d = LOAD;
      LOAD: begin
        state_d = PRE;
        cnt_d   = '0;
      end
      PRE:   state_d = EVAL;
      EVAL: begin
        if (mag_c != '0) begin
          state_d = ADD;
          sign_d  = ctl.Win[3];
          sel_d   = SEL_W'(mag_c - MAG_W'(1));
        end else begin
          state_d = SHIFT;
        end
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
        end else begin
          state_d = EVAL;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    load_d  = (state_d == LOAD);
    pre3_d  = (state_d == PRE);
    add_d   = (state_d == ADD) && !sign_d;
    addc_d  = (state_d == ADD) && sign_d;
    shift_d = (state_d == SHIFT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State, counter, captured digit and output registers; reset wins over all.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      pre3_q  <= 1'b0;
      add_q   <= 1'b0;
      addc_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      pre3_q  <= pre3_d;
      add_q   <= add_d;
      addc_q  <= addc_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ctl.Load  = load_q;
  assign ctl.Pre3  = pre3_q;
  assign ctl.Add   = add_q;
  assign ctl.Addc  = addc_q;
  assign ctl.Sel   = sel_q;
  assign ctl.Shift = shift_q;
  assign ctl.Busy  = busy_q;
  assign ctl.Done  = done_q;

endmodule

// File: tb/tb_booth8_ctrl.sv
// Bench for booth8_ctrl: cycle-level expected-trace model, small datapath model,
// and directed scenarios with literal latency / digit / product expectations.
module tb_booth8_ctrl;

  localparam logic [3:0] JUNKW = 4'b1010;

  typedef struct packed {
    logic [8:0] o;   // {Load,Pre3,Add,Addc,Sel[1:0],Shift,Busy,Done}
    logic [3:0] w;   // Win to present during this cycle
  } exp_t;
  typedef exp_t exp_q_t[$];

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  booth8_ctrl_if bus ();

  booth8_ctrl #(.ITER(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .ctl   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  bit   chk_en   = 0;
  int   load_cnt = 0;
  int   done_cnt = 0;
  logic [3:0] adds [$];
  logic [3:0] plan [3];
  exp_q_t     exp_q;

  logic [7:0]         dp_mplier, dp_mcand;
  logic signed [15:0] acc, m, m3;
  logic [8:0]         q;
  logic               q1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.Load, bus.Pre3, bus.Add, bus.Addc, bus.Sel, bus.Shift, bus.Busy, bus.Done};
  endfunction

  function automatic int digit(input logic [3:0] w);
    return -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
  endfunction

  function automatic exp_t mk(input logic ld, input logic pr, input logic ad, input logic ac,
                              input logic [1:0] sl, input logic sh, input logic dn,
                              input logic [3:0] w);
    exp_t e;
    e.o = {ld, pr, ad, ac, sl, sh, 1'b1, dn};
    e.w = w;
    return e;
  endfunction

  // Expected per-cycle trace of one whole operation, starting with the LOAD cycle.
  function automatic exp_q_t build(input logic [3:0] p [3]);
    exp_q_t s;
    int d, mag;
    s.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, JUNKW));
    s.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, JUNKW));
    for (int k = 0; k < 3; k++) begin
      d = digit(p[k]);
      s.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, p[k]));
      if (d != 0) begin
        mag = (d < 0) ? -d : d;
        s.push_back(mk(0, 0, d > 0, d < 0, 2'(mag - 1), 0, 0, JUNKW));
      end
      s.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, JUNKW));
    end
    s.push_back(mk(0, 0, 0, 0, 2'd0, 0, 1, JUNKW));
    return s;
  endfunction

  // Booth windows of the 9-bit sign-extended multiplier, least significant first.
  task automatic plan_from(input logic [7:0] mp);
    logic [8:0] qq;
    qq = {mp[7], mp};
    plan[0] = {qq[2:0], 1'b0};
    plan[1] = {qq[5:3], qq[2]};
    plan[2] = {qq[8:6], qq[5]};
  endtask

  // Model: advance the expected trace each edge; accept Start only when idle.
  always @(posedge Clock) begin : model
    bit idle_now;
    idle_now = (exp_q.size() == 0);
    if (Reset) begin
      exp_q.delete();
      chk_en = 1;
    end else if (!idle_now) begin
      void'(exp_q.pop_front());
    end else if (bus.Start) begin
      exp_q = build(plan);
      start_cyc = cyc;
    end
    cyc++;
  end

  // Compare every cycle against the model, drive Win, and tally pulses.
  always @(negedge Clock) begin : compare
    exp_t e;
    if (exp_q.size() != 0) e = exp_q[0];
    else                   e = '{o: 9'b0, w: JUNKW};
    if (chk_en) check("outputs", 32'(outs()), 32'(e.o));
    bus.Win = e.w;
    if (bus.Load === 1'b1) load_cnt++;
    if (bus.Done === 1'b1) done_cnt++;
    if (bus.Add === 1'b1 || bus.Addc === 1'b1) adds.push_back({bus.Add, bus.Addc, bus.Sel});
  end

  // Reference datapath driven by the controller's pulses.
  always @(posedge Clock) begin : datapath
    logic signed [25:0] x;
    logic signed [15:0] mult;
    case (bus.Sel)
      2'd0:    mult = m;
      2'd1:    mult = m <<< 1;
      2'd2:    mult = m3;
      default: mult = m <<< 2;
    endcase
    if (bus.Load === 1'b1) begin
      acc = '0;
      q   = {dp_mplier[7], dp_mplier};
      q1  = 1'b0;
      m   = 16'($signed(dp_mcand));
    end
    if (bus.Pre3 === 1'b1) m3 = m + (m <<< 1);
    if (bus.Add === 1'b1)  acc = acc + mult;
    if (bus.Addc === 1'b1) acc = acc - mult;
    if (bus.Shift === 1'b1) begin
      x = {acc, q, q1};
      x = x >>> 3;
      {acc, q, q1} = x;
    end
  end

  task automatic pulse_start();
    @(negedge Clock);
    bus.Start = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.Done !== 1'b1 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check("done_seen", 32'(bus.Done), 32'd1);
  endtask

  task automatic run_op(input string name, input int lat);
    adds.delete();
    pulse_start();
    wait_done(30);
    check({name, "_latency"}, 32'(cyc - start_cyc), 32'(lat));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_q_t pin;
    int n, low, d1, d2, l0, dn0;
    Reset = 1'b1;
    bus.Start = 1'b0;
    dp_mplier = 8'h00;
    dp_mcand  = 8'h00;
    plan = '{4'b0000, 4'b0000, 4'b0000};

    // Pin the trace model with hand-derived values.
    pin = build(plan);
    check("model_len_zero", 32'(pin.size()), 32'd9);
    pin = build('{4'b0111, 4'b0101, 4'b1000});
    check("model_len_full", 32'(pin.size()), 32'd12);
    check("model_first_add", 32'(pin[3].o), 32'(9'b001011010));
    check("model_done", 32'(pin[11].o), 32'(9'b000000011));

    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check("reset_outputs", 32'(outs()), 32'd0);

    // All-zero digits: no ADD cycles.
    plan = '{4'b0000, 4'b0000, 4'b0000};
    run_op("zero", 9);
    check("zero_adds", 32'(adds.size()), 32'd0);

    // Full digits +4, +3, -4.
    plan = '{4'b0111, 4'b0101, 4'b1000};
    run_op("full", 12);
    check("full_nadds", 32'(adds.size()), 32'd3);
    if (adds.size() == 3) begin
      check("full_it1", 32'(adds[0]), 32'(4'b1011));
      check("full_it2", 32'(adds[1]), 32'(4'b1010));
      check("full_it3", 32'(adds[2]), 32'(4'b0111));
    end

    // 1111 is a zero digit; then -2 and +1.
    plan = '{4'b1111, 4'b1100, 4'b0010};
    run_op("mixed", 11);
    check("mixed_nadds", 32'(adds.size()), 32'd2);
    if (adds.size() == 2) begin
      check("mixed_it2", 32'(adds[0]), 32'(4'b0101));
      check("mixed_it3", 32'(adds[1]), 32'(4'b1000));
    end

    // End to end: -1 * 7.
    dp_mplier = 8'hFF;
    dp_mcand  = 8'h07;
    plan_from(dp_mplier);
    run_op("dp", 10);
    check("dp_nadds", 32'(adds.size()), 32'd1);
    if (adds.size() == 1) check("dp_digit", 32'(adds[0]), 32'(4'b0100));
    check("dp_product", 32'({acc[6:0], q}), 32'h0000FFF9);

    // Reset in the first ADD, then a fresh operation two cycles later.
    @(negedge Clock);
    plan = '{4'b0111, 4'b0101, 4'b1000};
    pulse_start();
    n = 0;
    while (bus.Add !== 1'b1 && bus.Addc !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("midrst_in_add", 32'(bus.Add), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_pulses", 32'({bus.Add, bus.Addc, bus.Shift}), 32'd0);
    @(negedge Clock);
    plan_from(dp_mplier);
    run_op("post_rst", 10);
    check("post_rst_product", 32'({acc[6:0], q}), 32'h0000FFF9);

    // Start pulsed during the second SHIFT must be dropped.
    @(negedge Clock);
    plan = '{4'b0111, 4'b0101, 4'b1000};
    l0  = load_cnt;
    dn0 = done_cnt;
    pulse_start();
    n = 0;
    low = 0;
    while (low < 2 && n < 20) begin
      if (bus.Shift === 1'b1) low++;
      if (low < 2) begin
        @(negedge Clock);
        n++;
      end
    end
    bus.Start = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
    wait_done(20);
    check("busy_latency", 32'(cyc - start_cyc), 32'd12);
    repeat (6) @(negedge Clock);
    check("busy_loads", 32'(load_cnt - l0), 32'd1);
    check("busy_dones", 32'(done_cnt - dn0), 32'd1);

    // Start held high: Done recurs every latency+1 with one idle cycle between.
    plan = '{4'b0000, 4'b0000, 4'b0000};
    @(negedge Clock);
    bus.Start = 1'b1;
    wait_done(20);
    for (int r = 0; r < 2; r++) begin
      d1 = cyc;
      n = 0;
      low = 0;
      do begin
        @(negedge Clock);
        n++;
        if (bus.Busy !== 1'b1) low++;
      end while (bus.Done !== 1'b1 && n < 30);
      d2 = cyc;
      check("rep_period", 32'(d2 - d1), 32'd10);
      check("rep_idle_gap", 32'(low), 32'd1);
    end
    @(negedge Clock);
    bus.Start = 1'b0;
    repeat (12) @(negedge Clock);
    check("final_idle", 32'(outs()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
